// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I/M decode with registered control word, load-use bubble and forwarding selects
module rv_decode_stage #(
  parameter int FWD_DEPTH = 2,
  parameter bit ENABLE_M  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction,
  input  logic [31:0]          pc,
  input  logic                 flush,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_op,
  output logic                 out_illegal,
  output logic [4:0]           out_rd,
  output logic [31:0]          out_imm,
  output logic [31:0]          out_pc,
  output logic [FWD_DEPTH-1:0] out_fwd_rs1,
  output logic [FWD_DEPTH-1:0] out_fwd_rs2
);
  typedef struct packed {
    logic                 ill;
    logic [5:0]           op;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [FWD_DEPTH-1:0] f1;
    logic [FWD_DEPTH-1:0] f2;
  } word_t;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [5:0] op;
  logic [31:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic u1, u2, wr, ld;
  logic [4:0] rd;
  logic [FWD_DEPTH-1:0] f1, f2;
  logic adv, hazard, cap;
  word_t word_q, word_d;
  logic out_valid_q, out_valid_d;
  logic [FWD_DEPTH-1:0] hv_q, hv_d, hld_q, hld_d;
  logic [FWD_DEPTH-1:0][4:0] hrd_q, hrd_d;
  assign opc   = instruction[6:0];
  assign f3    = instruction[14:12];
  assign f7    = instruction[31:25];
  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
  always_comb begin
    op  = 6'd63;
    imm = '0;
    u1  = 1'b0;
    u2  = 1'b0;
    wr  = 1'b0;
    ld  = 1'b0;
    case (opc)
      7'b0110111: begin op = 6'd0; imm = imm_u; wr = 1'b1; end
      7'b0010111: begin op = 6'd1; imm = imm_u; wr = 1'b1; end
      7'b1101111: begin op = 6'd2; imm = imm_j; wr = 1'b1; end
      7'b1100111: begin op = f3 == 3'd0 ? 6'd3 : 6'd63; imm = imm_i; u1 = 1'b1; wr = 1'b1; end
      7'b1100011: begin
        op  = f3 < 3'd2 ? 6'd4 + {3'b0, f3} : f3 > 3'd3 ? 6'd2 + {3'b0, f3} : 6'd63;
        imm = imm_b; u1 = 1'b1; u2 = 1'b1;
      end
      7'b0000011: begin
        op  = f3 < 3'd3 ? 6'd10 + {3'b0, f3} : (f3 == 3'd4 || f3 == 3'd5) ? 6'd9 + {3'b0, f3} : 6'd63;
        imm = imm_i; u1 = 1'b1; wr = 1'b1; ld = 1'b1;
      end
      7'b0100011: begin op = f3 < 3'd3 ? 6'd15 + {3'b0, f3} : 6'd63; imm = imm_s; u1 = 1'b1; u2 = 1'b1; end
      7'b0010011: begin
        op  = f3 == 3'd0 ? 6'd18 :
              f3 == 3'd1 ? (f7 == 7'h00 ? 6'd24 : 6'd63) :
              f3 == 3'd5 ? (f7 == 7'h00 ? 6'd25 : f7 == 7'h20 ? 6'd26 : 6'd63) :
              f3 == 3'd6 ? 6'd22 : f3 == 3'd7 ? 6'd23 : 6'd17 + {3'b0, f3};
        imm = imm_i; u1 = 1'b1; wr = 1'b1;
      end
      7'b0110011: begin
        op = f7 == 7'h00 ? (f3 == 3'd0 ? 6'd27 : f3 < 3'd6 ? 6'd28 + {3'b0, f3} : 6'd29 + {3'b0, f3}) :
             f7 == 7'h20 ? (f3 == 3'd0 ? 6'd28 : f3 == 3'd5 ? 6'd34 : 6'd63) :
             (f7 == 7'h01 && ENABLE_M) ? 6'd37 + {3'b0, f3} : 6'd63;
        u1 = 1'b1; u2 = 1'b1; wr = 1'b1;
      end
      default: op = 6'd63;
    endcase
    if (op == 6'd63) begin
      imm = '0;
      u1  = 1'b0;
      u2  = 1'b0;
      wr  = 1'b0;
      ld  = 1'b0;
    end
  end
  assign rs1 = u1 ? instruction[19:15] : 5'd0;
  assign rs2 = u2 ? instruction[24:20] : 5'd0;
  assign rd  = wr ? instruction[11:7] : 5'd0;
  // scan oldest to youngest so the youngest matching producer wins
  always_comb begin
    f1 = '0;
    f2 = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hv_q[k] && rs1 != 5'd0 && hrd_q[k] == rs1) begin
        f1    = '0;
        f1[k] = 1'b1;
      end
      if (hv_q[k] && rs2 != 5'd0 && hrd_q[k] == rs2) begin
        f2    = '0;
        f2[k] = 1'b1;
      end
    end
  end
  assign adv      = ~out_valid_q | out_ready;
  assign hazard   = in_valid & hv_q[0] & hld_q[0] &
                    ((rs1 != 5'd0 && rs1 == hrd_q[0][4:0]) || (rs2 != 5'd0 && rs2 == hrd_q[0][4:0]));
  assign in_ready = adv & ~hazard & ~flush;
  assign cap      = in_valid & in_ready;
  always_comb begin
    word_d      = word_q;
    out_valid_d = out_valid_q;
    hv_d        = hv_q;
    hrd_d       = hrd_q;
    hld_d       = hld_q;
    if (flush) begin
      out_valid_d = 1'b0;
      hv_d        = '0;
    end else if (adv) begin
      out_valid_d = cap;
      word_d      = cap ? {op == 6'd63, op, rd, imm, pc, f1, f2} : word_q;
      hv_d        = {hv_q[FWD_DEPTH-2:0], cap && rd != 5'd0};
      hrd_d       = {hrd_q[FWD_DEPTH-2:0], cap ? rd : 5'd0};
      hld_d       = {hld_q[FWD_DEPTH-2:0], cap && ld};
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q      <= '0;
      out_valid_q <= 1'b0;
      hv_q        <= '0;
      hrd_q       <= '0;
      hld_q       <= '0;
    end else begin
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      hv_q        <= hv_d;
      hrd_q       <= hrd_d;
      hld_q       <= hld_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign out_illegal = word_q.ill;
  assign out_op      = word_q.op;
  assign out_rd      = word_q.rd;
  assign out_imm     = word_q.imm;
  assign out_pc      = word_q.pc;
  assign out_fwd_rs1 = word_q.f1;
  assign out_fwd_rs2 = word_q.f2;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: table-driven decode vectors plus hand sequences for hazards, stalls, flush and reset
module tb_rv_decode_stage;
  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0, pc = '0;
  logic in_ready, out_valid, out_illegal;
  logic [4:0] rs1, rs2, out_rd;
  logic [5:0] out_op;
  logic [31:0] out_imm, out_pc;
  logic [1:0] fwd1, fwd2;
  logic n_in_ready, n_out_valid, n_out_illegal;
  logic [4:0] n_rs1, n_rs2, n_out_rd;
  logic [5:0] n_out_op;
  logic [31:0] n_out_imm, n_out_pc;
  logic [1:0] n_fwd1, n_fwd2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rv_decode_stage #(.FWD_DEPTH(2), .ENABLE_M(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .instruction(instr), .pc(pc),
    .flush(flush), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_illegal(out_illegal), .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
    .out_fwd_rs1(fwd1), .out_fwd_rs2(fwd2));
  rv_decode_stage #(.FWD_DEPTH(2), .ENABLE_M(1'b0)) u_nom (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(n_in_ready), .instruction(instr), .pc(pc),
    .flush(flush), .rs1(n_rs1), .rs2(n_rs2), .out_valid(n_out_valid), .out_ready(out_ready), .out_op(n_out_op),
    .out_illegal(n_out_illegal), .out_rd(n_out_rd), .out_imm(n_out_imm), .out_pc(n_out_pc),
    .out_fwd_rs1(n_fwd1), .out_fwd_rs2(n_fwd2));
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] i, input logic [31:0] p);
    int n = 0;
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    #1;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck low for inst %h", i);
    end
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    tbl.push_back('{32'h123452B7, 32'h0, 6'd0, 5'd5, 32'h12345000, 1'b0, 5'd0, 5'd0});
    tbl.push_back('{32'h00001317, 32'h4, 6'd1, 5'd6, 32'h00001000, 1'b0, 5'd0, 5'd0});
    tbl.push_back('{32'h008000EF, 32'h8, 6'd2, 5'd1, 32'h00000008, 1'b0, 5'd0, 5'd0});
    tbl.push_back('{32'h00008067, 32'hC, 6'd3, 5'd0, 32'h00000000, 1'b0, 5'd1, 5'd0});
    tbl.push_back('{32'hFE208EE3, 32'h10, 6'd4, 5'd0, 32'hFFFFFFFC, 1'b0, 5'd1, 5'd2});
    tbl.push_back('{32'hFE20FEE3, 32'h14, 6'd9, 5'd0, 32'hFFFFFFFC, 1'b0, 5'd1, 5'd2});
    tbl.push_back('{32'hFE20AEE3, 32'h18, 6'd63, 5'd0, 32'h00000000, 1'b1, 5'd0, 5'd0});
    tbl.push_back('{32'hFFF14383, 32'h1C, 6'd13, 5'd7, 32'hFFFFFFFF, 1'b0, 5'd2, 5'd0});
    tbl.push_back('{32'h0020A423, 32'h20, 6'd17, 5'd0, 32'h00000008, 1'b0, 5'd1, 5'd2});
    tbl.push_back('{32'h40315093, 32'h24, 6'd26, 5'd1, 32'h00000403, 1'b0, 5'd2, 5'd0});
    tbl.push_back('{32'h40311093, 32'h28, 6'd63, 5'd0, 32'h00000000, 1'b1, 5'd0, 5'd0});
    tbl.push_back('{32'h402081B3, 32'h2C, 6'd28, 5'd3, 32'h00000000, 1'b0, 5'd1, 5'd2});
    tbl.push_back('{32'h00A4F433, 32'h30, 6'd36, 5'd8, 32'h00000000, 1'b0, 5'd9, 5'd10});
    tbl.push_back('{32'h02D675B3, 32'h34, 6'd44, 5'd11, 32'h00000000, 1'b0, 5'd12, 5'd13});
    tbl.push_back('{32'h0000007F, 32'h38, 6'd63, 5'd0, 32'h00000000, 1'b1, 5'd0, 5'd0});
    tbl.push_back('{32'h4020D1B3, 32'h3C, 6'd34, 5'd3, 32'h00000000, 1'b0, 5'd1, 5'd2});
    // reset state
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_fwd", {fwd1, fwd2}, 0);
    chk("rst_in_ready", in_ready, 1);
    rstn = 1'b1;
    tick();
    // single addi, then dependent add back-to-back
    send(32'h00500093, 32'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_op", out_op, 18);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_fwd", {fwd1, fwd2}, 0);
    send(32'h00108133, 32'h104);
    chk("add_op", out_op, 27);
    chk("add_fwd1", fwd1, 2'b01);
    chk("add_fwd2", fwd2, 2'b01);
    // load-use bubble
    send(32'h00002183, 32'h108);
    chk("lw_op", out_op, 12);
    in_valid = 1'b1;
    instr    = 32'h00018233;
    pc       = 32'h10C;
    #1;
    chk("lu_in_ready_low", in_ready, 0);
    tick();
    chk("lu_bubble_valid", out_valid, 0);
    chk("lu_in_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_rd", out_rd, 4);
    chk("lu_add_fwd1", fwd1, 2'b10);
    chk("lu_add_fwd2", fwd2, 2'b00);
    // three cycles of backpressure
    send(32'h00700313, 32'h110);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h000303B3;
    pc        = 32'h114;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_op", out_op, 18);
      chk("bp_rd", out_rd, 6);
      chk("bp_imm", out_imm, 7);
      chk("bp_pc", out_pc, 32'h110);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_add_op", out_op, 27);
    chk("bp_add_rd", out_rd, 7);
    chk("bp_add_fwd1", fwd1, 2'b01);
    // x0 never forwards
    send(32'h00000013, 32'h120);
    chk("x0_addi_rd", out_rd, 0);
    send(32'h000002B3, 32'h124);
    chk("x0_add_fwd", {fwd1, fwd2}, 0);
    // flush drops the pending add and clears history
    send(32'h00500093, 32'h128);
    in_valid = 1'b1;
    instr    = 32'h00108133;
    pc       = 32'h12C;
    flush    = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    send(32'h00108133, 32'h130);
    chk("fl_add_valid", out_valid, 1);
    chk("fl_add_pc", out_pc, 32'h130);
    chk("fl_add_fwd", {fwd1, fwd2}, 0);
    // M extension enabled vs disabled
    send(32'h023100B3, 32'h134);
    chk("m_on_op", out_op, 37);
    chk("m_on_rd", out_rd, 1);
    chk("m_on_ill", out_illegal, 0);
    chk("m_off_op", n_out_op, 63);
    chk("m_off_rd", n_out_rd, 0);
    chk("m_off_ill", n_out_illegal, 1);
    chk("m_off_valid", n_out_valid, 1);
    // decode table
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      instr    = tbl[i].inst;
      pc       = tbl[i].pc;
      #1;
      chk($sformatf("tbl%0d_rs1", i), rs1, tbl[i].rs1);
      chk($sformatf("tbl%0d_rs2", i), rs2, tbl[i].rs2);
      send(tbl[i].inst, tbl[i].pc);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_op", i), out_op, tbl[i].op);
      chk($sformatf("tbl%0d_rd", i), out_rd, tbl[i].rd);
      chk($sformatf("tbl%0d_imm", i), out_imm, tbl[i].imm);
      chk($sformatf("tbl%0d_ill", i), out_illegal, tbl[i].ill);
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].pc);
    end
    // asynchronous reset mid-stream
    send(32'h00500093, 32'h200);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_op", out_op, 0);
    chk("ar_pc", out_pc, 0);
    tick();
    rstn = 1'b1;
    send(32'h00108133, 32'h204);
    chk("ar_first_valid", out_valid, 1);
    chk("ar_first_pc", out_pc, 32'h204);
    chk("ar_hist_cleared", {fwd1, fwd2}, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
